data_reg_bank: RTL and testbench

Ten-entry, 32-bit register bank holding neuron data for the neural-network datapath. Supports two write modes: a bulk load of all ten registers from parallel inputs, and a single addressed write from one data port. All ten register contents are driven continuously on parallel outputs for downstream neuron/MAC logic.

---
 rtl/data_reg_bank_pkg.sv | 15 +
 rtl/data_reg_bank_if.sv | 33 +++
 rtl/data_reg_cell.sv | 41 ++++
 rtl/data_reg_bank.sv | 83 ++++++++
 tb/tb_data_reg_bank.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/data_reg_bank_pkg.sv
// Shared constants and types for the neuron-data register bank.
package data_reg_bank_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 10;
    localparam int ADDR_W   = 4;

    typedef logic [DATA_W-1:0] data_t;

    // True when an address names one of the physical registers.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (int'(addr) < NUM_REGS);
    endfunction

endpackage : data_reg_bank_pkg

// File: rtl/data_reg_bank_if.sv
// Bundle of the register bank's data/control signals, used to drive and
// observe the bank as a group. The master side writes, the slave side holds
// the registers.
interface data_reg_bank_if
    import data_reg_bank_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [WIDTH-1:0]  in_data  [NUM_REGS];
    logic [WIDTH-1:0]  data_in;
    logic [ADDR_W-1:0] address;
    logic              write_address;
    logic              write_all;
    logic [WIDTH-1:0]  out_data [NUM_REGS];

    modport master (
        output in_data,
        output data_in,
        output address,
        output write_address,
        output write_all,
        input  out_data
    );

    modport slave (
        input  in_data,
        input  data_in,
        input  address,
        input  write_address,
        input  write_all,
        output out_data
    );
endinterface : data_reg_bank_if

// File: rtl/data_reg_cell.sv
// One register of the bank: reset beats bulk load, bulk load beats the
// addressed load, otherwise the value is held.
module data_reg_cell
    import data_reg_bank_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             loadAll,
    input  logic [WIDTH-1:0] allData,
    input  logic             loadSel,
    input  logic [WIDTH-1:0] selData,
    output logic [WIDTH-1:0] dataOut
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-value select: bulk load has priority over the addressed write.
    always_comb begin
        data_d = data_q;
        if (loadAll) begin
            data_d = allData;
        end else if (loadSel) begin
            data_d = selData;
        end
    end

    // Storage with synchronous active-low clear that overrides any load.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign dataOut = data_q;

endmodule : data_reg_cell

// File: rtl/data_reg_bank.sv
// Ten-entry register bank for neuron data. Port list keeps the legacy
// positional order (resetN last). This level only decodes the write address
// and wires ports to the ten register cells.
module data_reg_bank
    import data_reg_bank_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0]  in0,
    input  logic [WIDTH-1:0]  in1,
    input  logic [WIDTH-1:0]  in2,
    input  logic [WIDTH-1:0]  in3,
    input  logic [WIDTH-1:0]  in4,
    input  logic [WIDTH-1:0]  in5,
    input  logic [WIDTH-1:0]  in6,
    input  logic [WIDTH-1:0]  in7,
    input  logic [WIDTH-1:0]  in8,
    input  logic [WIDTH-1:0]  in9,
    input  logic [WIDTH-1:0]  dataIn,
    input  logic [ADDR_W-1:0] address,
    input  logic              writeAddress,
    input  logic              writeAll,
    input  logic              clk,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic [WIDTH-1:0]  out4,
    output logic [WIDTH-1:0]  out5,
    output logic [WIDTH-1:0]  out6,
    output logic [WIDTH-1:0]  out7,
    output logic [WIDTH-1:0]  out8,
    output logic [WIDTH-1:0]  out9,
    input  logic              resetN
);

    logic [WIDTH-1:0]    bulk_data [NUM_REGS];
    logic [WIDTH-1:0]    cell_q    [NUM_REGS];
    logic [NUM_REGS-1:0] load_sel;

    assign bulk_data[0] = in0;
    assign bulk_data[1] = in1;
    assign bulk_data[2] = in2;
    assign bulk_data[3] = in3;
    assign bulk_data[4] = in4;
    assign bulk_data[5] = in5;
    assign bulk_data[6] = in6;
    assign bulk_data[7] = in7;
    assign bulk_data[8] = in8;
    assign bulk_data[9] = in9;

    // Exact-match decode: addresses 10..15 select no cell, so such writes
    // are dropped rather than aliased onto a real register.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
            assign load_sel[gi] = writeAddress & (address == ADDR_W'(gi));

            data_reg_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk     (clk),
                .resetN  (resetN),
                .loadAll (writeAll),
                .allData (bulk_data[gi]),
                .loadSel (load_sel[gi]),
                .selData (dataIn),
                .dataOut (cell_q[gi])
            );
        end
    endgenerate

    assign out0 = cell_q[0];
    assign out1 = cell_q[1];
    assign out2 = cell_q[2];
    assign out3 = cell_q[3];
    assign out4 = cell_q[4];
    assign out5 = cell_q[5];
    assign out6 = cell_q[6];
    assign out7 = cell_q[7];
    assign out8 = cell_q[8];
    assign out9 = cell_q[9];

endmodule : data_reg_bank

// File: tb/tb_data_reg_bank.sv
// Bench for data_reg_bank: directed scenarios followed by random traffic,
// all checked against a simple array model of the ten registers.
module tb_data_reg_bank;
    import data_reg_bank_pkg::*;

    logic clk;
    logic resetN;

    int tests_run;
    int tests_failed;

    logic [DATA_W-1:0] model_regs [NUM_REGS];

    data_reg_bank_if #(.WIDTH(DATA_W)) bus ();

    data_reg_bank #(.WIDTH(DATA_W)) dut (
        .in0          (bus.in_data[0]),
        .in1          (bus.in_data[1]),
        .in2          (bus.in_data[2]),
        .in3          (bus.in_data[3]),
        .in4          (bus.in_data[4]),
        .in5          (bus.in_data[5]),
        .in6          (bus.in_data[6]),
        .in7          (bus.in_data[7]),
        .in8          (bus.in_data[8]),
        .in9          (bus.in_data[9]),
        .dataIn       (bus.data_in),
        .address      (bus.address),
        .writeAddress (bus.write_address),
        .writeAll     (bus.write_all),
        .clk          (clk),
        .out0         (bus.out_data[0]),
        .out1         (bus.out_data[1]),
        .out2         (bus.out_data[2]),
        .out3         (bus.out_data[3]),
        .out4         (bus.out_data[4]),
        .out5         (bus.out_data[5]),
        .out6         (bus.out_data[6]),
        .out7         (bus.out_data[7]),
        .out8         (bus.out_data[8]),
        .out9         (bus.out_data[9]),
        .resetN       (resetN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply the currently driven stimulus for one clock edge, advance the
    // model by the bank's rules, then compare every output.
    task automatic run_cycle(input string name);
        if (!resetN) begin
            for (int k = 0; k < NUM_REGS; k++) model_regs[k] = '0;
        end else if (bus.write_all) begin
            for (int k = 0; k < NUM_REGS; k++) model_regs[k] = bus.in_data[k];
        end else if (bus.write_address && int'(bus.address) < NUM_REGS) begin
            model_regs[int'(bus.address)] = bus.data_in;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_REGS; k++) begin
            check_val($sformatf("%s out%0d", name, k), bus.out_data[k], model_regs[k]);
        end
        $display("[TB] %-10s rst_n=%0b wall=%0b wadr=%0b addr=%0d din=%h out0=%h out9=%h",
                 name, resetN, bus.write_all, bus.write_address, bus.address,
                 bus.data_in, bus.out_data[0], bus.out_data[9]);
    endtask

    task automatic idle_inputs();
        bus.write_all     = 1'b0;
        bus.write_address = 1'b0;
        bus.address       = '0;
        bus.data_in       = '0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetN       = 1'b1;
        idle_inputs();
        for (int k = 0; k < NUM_REGS; k++) bus.in_data[k] = '1;

        // Reset overrides an active bulk load of all-ones.
        resetN        = 1'b0;
        bus.write_all = 1'b1;
        run_cycle("reset");
        resetN = 1'b1;
        run_cycle("rel_load");
        bus.write_all = 1'b0;

        // Addressed sweep: register K gets value K.
        for (int k = 0; k < NUM_REGS; k++) begin
            bus.write_address = 1'b1;
            bus.address       = ADDR_W'(k);
            bus.data_in       = DATA_W'(k);
            run_cycle("sweep");
        end
        idle_inputs();
        run_cycle("sweep_hold");

        // Bulk load 10..19, then hold after deassert.
        for (int k = 0; k < NUM_REGS; k++) bus.in_data[k] = DATA_W'(10 + k);
        bus.write_all = 1'b1;
        run_cycle("bulk");
        bus.write_all = 1'b0;
        run_cycle("bulk_hold");

        // Bulk load wins over a simultaneous addressed write.
        bus.in_data[3]    = 32'h33;
        bus.write_all     = 1'b1;
        bus.write_address = 1'b1;
        bus.address       = 4'd3;
        bus.data_in       = 32'hAA;
        run_cycle("priority");
        idle_inputs();

        // Preload K, then out-of-range addresses must change nothing.
        for (int k = 0; k < NUM_REGS; k++) bus.in_data[k] = DATA_W'(k);
        bus.write_all = 1'b1;
        run_cycle("preload");
        bus.write_all = 1'b0;
        for (int a = 10; a < 16; a++) begin
            bus.write_address = 1'b1;
            bus.address       = ADDR_W'(a);
            bus.data_in       = 32'hDEAD;
            run_cycle("oor");
        end
        idle_inputs();

        // Hold for five cycles, then reset during an addressed write.
        for (int i = 0; i < 5; i++) run_cycle("hold");
        resetN            = 1'b0;
        bus.write_address = 1'b1;
        bus.address       = 4'd2;
        bus.data_in       = 32'h1234_5678;
        run_cycle("mid_reset");
        resetN = 1'b1;
        idle_inputs();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            resetN            = ($urandom_range(0, 19) != 0);
            bus.write_all     = ($urandom_range(0, 4) == 0);
            bus.write_address = ($urandom_range(0, 1) == 0);
            bus.address       = ADDR_W'($urandom_range(0, 15));
            bus.data_in       = $urandom;
            for (int k = 0; k < NUM_REGS; k++) bus.in_data[k] = $urandom;
            run_cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_data_reg_bank
